// File: rtl/regfile_arb_pkg.sv
// Shared constants for the register-file write-port arbiter.
// Requester index constants name the usual writeback sources.
package regfile_arb_pkg;
    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_LINK = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus its binary index.
// The scan starts at ptr_i and wraps modulo N.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);
    int   cand;
    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr_i) + k) % N;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates NREQ writeback sources onto the register file's single write port.
// Build option REGFILE_ARB_R0_ZERO_EN: writes to r0 are dropped and r0 never flags a hazard.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DBITS = 32,
    parameter int NREQ  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       hold,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [REG_ADDR_W*NREQ-1:0] req_rd,
    input  logic [DBITS*NREQ-1:0]      req_data,
    output logic                       rf_wrtEn,
    output logic [REG_ADDR_W-1:0]      rf_rd,
    output logic [DBITS-1:0]           rf_wrtData,
    input  logic [REG_ADDR_W-1:0]      rs1,
    input  logic [REG_ADDR_W-1:0]      rs2,
    output logic                       hazard1,
    output logic                       hazard2
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  wrten_q, wrten_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [DBITS-1:0]      data_q, data_d;

    logic [NREQ-1:0]       arb_req;
    logic [NREQ-1:0]       grant;
    logic [PW-1:0]         gidx;
    logic                  accept;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [DBITS-1:0]      sel_data;

    assign arb_req = (reset || hold) ? '0 : req_valid;

    rr_arbiter #(.N(NREQ), .IW(PW)) u_rr (
        .req_i   (arb_req),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gidx)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign sel_rd    = req_rd[REG_ADDR_W*gidx +: REG_ADDR_W];
    assign sel_data  = req_data[DBITS*gidx +: DBITS];

    always_comb begin
        ptr_d   = ptr_q;
        wrten_d = 1'b0;
        rd_d    = rd_q;
        data_d  = data_q;
        if (accept) begin
            ptr_d  = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            rd_d   = sel_rd;
            data_d = sel_data;
`ifdef REGFILE_ARB_R0_ZERO_EN
            // r0 writes still take their slot so fairness is unaffected
            wrten_d = (sel_rd != '0);
`else
            wrten_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            wrten_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wrten_q <= wrten_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assign rf_wrtEn   = wrten_q;
    assign rf_rd      = rd_q;
    assign rf_wrtData = data_q;

    always_comb begin
        hazard1 = wrten_q && (rd_q == rs1);
        hazard2 = wrten_q && (rd_q == rs2);
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && (req_rd[REG_ADDR_W*i +: REG_ADDR_W] == rs1)) hazard1 = 1'b1;
            if (req_valid[i] && (req_rd[REG_ADDR_W*i +: REG_ADDR_W] == rs2)) hazard2 = 1'b1;
        end
`ifdef REGFILE_ARB_R0_ZERO_EN
        if (rs1 == '0) hazard1 = 1'b0;
        if (rs2 == '0) hazard2 = 1'b0;
`endif
    end
endmodule
